can_fixed_field_checker: RTL and testbench

//  Generalised fixed-form field checker for the CAN decoder. It verifies a run of FIELD_LEN recessive bits
//  (EOF, intermission, CRC/ACK delimiters) sampled at the bit sample point.
//  - Flags a form error and records the offending bit index.
//  - In receiver mode, reports a dominant last bit as an overload request instead of an error.
//  - Sits after the bit-timing unit; the frame FSM starts it.

---
 rtl/can_pkg.sv | 17 +
 rtl/can_sat_counter.sv | 41 ++++
 rtl/can_fixed_field_checker.sv | 128 ++++++++++++
 tb/tb_can_fixed_field_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN decoder types and constants: checker state encoding, bus levels
// and the lengths of the fixed-form fields.
package can_pkg;

  typedef enum logic {
    FFC_IDLE  = 1'b0,
    FFC_CHECK = 1'b1
  } ffc_state_e;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

  localparam int CAN_EOF_LEN          = 7;
  localparam int CAN_INTERMISSION_LEN = 3;
  localparam int CAN_DELIM_LEN        = 1;

endpackage

// File: rtl/can_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module can_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // next count: clear wins over increment, increment stops at the ceiling
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = {WIDTH{1'b0}};
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/can_fixed_field_checker.sv
// Checks a run of FIELD_LEN recessive bits (EOF, intermission, delimiters) at the sample point.
// Define CAN_FFC_STATS_EN to add the saturating err_count_o form-error counter.
module can_fixed_field_checker
  import can_pkg::*;
#(
  parameter int FIELD_LEN         = 7,
  parameter int CNT_W             = 4,
  parameter int LAST_BIT_OVERLOAD = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sample_point_i,
  input  logic             rx_i,
  input  logic             start_i,
  input  logic             is_tx_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             form_error_o,
  output logic             overload_req_o,
  output logic [CNT_W-1:0] err_bit_idx_o
`ifdef CAN_FFC_STATS_EN
  ,
  output logic [7:0]       err_count_o
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FIELD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             OVL_EN   = (LAST_BIT_OVERLOAD != 0);

  ffc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             ovl_q, ovl_d;

  // next state; a start always wins so a restart discards the in-flight sample
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovl_d   = 1'b0;
    case (state_q)
      FFC_IDLE: begin
        if (start_i) begin
          state_d = FFC_CHECK;
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {CNT_W{1'b0}};
        end else begin
          state_d = FFC_IDLE;
        end
      end
      FFC_CHECK: begin
        if (start_i) begin
          cnt_d = {CNT_W{1'b0}};
          idx_d = {CNT_W{1'b0}};
        end else if (sample_point_i) begin
          if (rx_i == CAN_RECESSIVE) begin
            if (cnt_q == LAST_IDX) begin
              done_d  = 1'b1;
              state_d = FFC_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if ((cnt_q == LAST_IDX) && !is_tx_i && OVL_EN) begin
            ovl_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FFC_IDLE;
          end else begin
            ferr_d  = 1'b1;
            idx_d   = cnt_q;
            state_d = FFC_IDLE;
          end
        end else begin
          state_d = FFC_CHECK;
        end
      end
      default: begin
        state_d = FFC_IDLE;
      end
    endcase
    busy_d = (state_d == FFC_CHECK);
  end

  // state, counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FFC_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      idx_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovl_q   <= ovl_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign form_error_o   = ferr_q;
  assign overload_req_o = ovl_q;
  assign err_bit_idx_o  = idx_q;

`ifdef CAN_FFC_STATS_EN
  can_sat_counter #(
    .WIDTH(8)
  ) u_err_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(1'b0),
    .inc_i  (ferr_d),
    .count_o(err_count_o)
  );
`endif

endmodule

// File: tb/tb_can_fixed_field_checker.sv
// Scoreboard bench: a 7-bit and a 3-bit checker share one stimulus stream,
// each compared every cycle against its own behavioural model.
module tb_can_fixed_field_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sp, rx, st, tx;
  logic busy0, done0, ferr0, ovl0;
  logic busy1, done1, ferr1, ovl1;
  logic [3:0] idx0, idx1;
  logic [7:0] ec0, ec1;

  typedef struct {
    bit busy; bit done; bit ferr; bit ovl;
    int cnt;  int idx;  int errs;
  } m_t;

  typedef struct {
    string      tag;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] c0;
    logic [7:0] c1;
  } exp_t;

  exp_t sb[$];
  m_t   m0, m1;
  int   n_checks = 0;
  int   n_errors = 0;

  can_fixed_field_checker u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .sample_point_i(sp), .rx_i(rx), .start_i(st), .is_tx_i(tx),
    .busy_o(busy0), .done_o(done0), .form_error_o(ferr0), .overload_req_o(ovl0),
`ifdef CAN_FFC_STATS_EN
    .err_count_o(ec0),
`endif
    .err_bit_idx_o(idx0)
  );

  can_fixed_field_checker #(.FIELD_LEN(3), .CNT_W(4), .LAST_BIT_OVERLOAD(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .sample_point_i(sp), .rx_i(rx), .start_i(st), .is_tx_i(tx),
    .busy_o(busy1), .done_o(done1), .form_error_o(ferr1), .overload_req_o(ovl1),
`ifdef CAN_FFC_STATS_EN
    .err_count_o(ec1),
`endif
    .err_bit_idx_o(idx1)
  );

`ifndef CAN_FFC_STATS_EN
  assign ec0 = 8'h00;
  assign ec1 = 8'h00;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic m_t m_clear();
    m_t s;
    s.busy = 1'b0; s.done = 1'b0; s.ferr = 1'b0; s.ovl = 1'b0;
    s.cnt = 0; s.idx = 0; s.errs = 0;
    return s;
  endfunction

  function automatic m_t m_step(input m_t s, input int len, input bit st_v, input bit sp_v,
                                input bit rx_v, input bit tx_v);
    s.done = 1'b0; s.ferr = 1'b0; s.ovl = 1'b0;
    if (st_v) begin
      s.busy = 1'b1; s.cnt = 0; s.idx = 0;
    end else if (s.busy && sp_v) begin
      if (rx_v) begin
        if (s.cnt == len - 1) begin s.done = 1'b1; s.busy = 1'b0; end
        else s.cnt++;
      end else if (s.cnt == len - 1 && !tx_v) begin
        s.ovl = 1'b1; s.done = 1'b1; s.busy = 1'b0;
      end else begin
        s.ferr = 1'b1; s.idx = s.cnt; s.busy = 1'b0;
        if (s.errs < 255) s.errs++;
      end
    end
    return s;
  endfunction

  function automatic logic [7:0] m_pack(input m_t s);
    logic [3:0] i4;
    i4 = 4'(s.idx);
    return {s.busy, s.done, s.ferr, s.ovl, i4};
  endfunction

  // one clock: drive, predict, then compare the registered response
  task automatic cyc(input bit st_v, input bit sp_v, input bit rx_v, input bit tx_v, input string tag);
    exp_t e;
    st = st_v; sp = sp_v; rx = rx_v; tx = tx_v;
    m0 = m_step(m0, 7, st_v, sp_v, rx_v, tx_v);
    m1 = m_step(m1, 3, st_v, sp_v, rx_v, tx_v);
    e.tag = tag; e.e0 = m_pack(m0); e.e1 = m_pack(m1);
    e.c0 = 8'(m0.errs); e.c1 = 8'(m1.errs);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check_eq({e.tag, "/len7"}, {busy0, done0, ferr0, ovl0, idx0}, e.e0);
    check_eq({e.tag, "/len3"}, {busy1, done1, ferr1, ovl1, idx1}, e.e1);
`ifdef CAN_FFC_STATS_EN
    check_eq({e.tag, "/cnt7"}, ec0, e.c0);
    check_eq({e.tag, "/cnt3"}, ec1, e.c1);
`endif
  endtask

  task automatic bit_s(input bit r, input bit t, input string tag);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, tag);
    cyc(1'b0, 1'b1, r, t, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq({tag, "/len7"}, {busy0, done0, ferr0, ovl0, idx0}, 32'h0);
    check_eq({tag, "/len3"}, {busy1, done1, ferr1, ovl1, idx1}, 32'h0);
    check_eq({tag, "/cnt"}, {ec0, ec1}, 32'h0);
    m0 = m_clear(); m1 = m_clear(); sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    st = 1'b0; sp = 1'b0; rx = 1'b1; tx = 1'b0;
    rst_n = 1'b0;
    m0 = m_clear(); m1 = m_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // 1: clean field, plus sample points in idle that must be ignored
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "idle_sp");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "t1_start");
    repeat (7) bit_s(1'b1, 1'b0, "t1_bit");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "t1_after");

    // 2: dominant bit 3, later samples produce nothing
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "t2_start");
    repeat (3) bit_s(1'b1, 1'b0, "t2_bit");
    bit_s(1'b0, 1'b0, "t2_err");
    repeat (3) bit_s(1'b0, 1'b0, "t2_tail");

    // 3: dominant last bit as receiver, then as transmitter
    for (int t = 0; t < 2; t++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, "t3_start");
      repeat (6) bit_s(1'b1, 1'b0, "t3_bit");
      bit_s(1'b0, t[0], t == 0 ? "t3_rx_last" : "t3_tx_last");
    end

    // 4: error at bit 0, next field clears the index
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "t4_start");
    bit_s(1'b0, 1'b0, "t4_err0");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "t4_restart");
    repeat (7) bit_s(1'b1, 1'b0, "t4_bit");

    // 5: start with a coincident sample, restart mid-field, then reset mid-field
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "t5_start_sp");
    repeat (5) bit_s(1'b1, 1'b0, "t5_bit");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, "t5_restart");
    repeat (7) bit_s(1'b1, 1'b0, "t5_bit2");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "t5_start2");
    repeat (2) bit_s(1'b1, 1'b0, "t5_bit3");
    do_reset("t5_midreset");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, "t5_post");

    // 6: 300 bit-1 errors saturate the counter; an overload does not count
    for (int n = 0; n < 300; n++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, "t6_start");
      bit_s(1'b1, 1'b0, "t6_b0");
      bit_s(1'b0, 1'b0, "t6_b1");
    end
`ifdef CAN_FFC_STATS_EN
    check_eq("t6_sat", ec1, 32'd255);
`endif
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "t6_ovl_start");
    repeat (2) bit_s(1'b1, 1'b0, "t6_ovl_bit");
    bit_s(1'b0, 1'b0, "t6_ovl_last");
`ifdef CAN_FFC_STATS_EN
    check_eq("t6_ovl_cnt", ec1, 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
